// File: rtl/j1_stack_v2_pkg.sv
// Shared J1 stack types and default sizes used by the data and return stacks.
package j1_stack_v2_pkg;

   localparam int J1_WIDTH        = 16;
   localparam int J1_DSTACK_DEPTH = 32;
   localparam int J1_RSTACK_DEPTH = 32;

   // Same encoding as the alu dstack/rstack fields of the instruction word
   typedef logic signed [1:0] stack_delta_t;

   typedef enum logic {
      STACK_WRAP  = 1'b0,
      STACK_GUARD = 1'b1
   } stack_mode_t;

endpackage

// File: rtl/j1_stack_ptr.sv
// Stack pointer / occupancy arithmetic with wrap-or-guard stepping and sticky error flags.
module j1_stack_ptr
   import j1_stack_v2_pkg::*;
#(
   parameter int DEPTH   = J1_DSTACK_DEPTH,
   parameter int DELTA_W = 2,
   parameter int WRAP    = 1,
   localparam int AW     = $clog2(DEPTH),
   localparam int CW     = AW + 1
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      en,
   input  logic signed [DELTA_W-1:0] delta,
   input  logic                      err_clr,
   output logic [AW-1:0]             sp,
   output logic [AW-1:0]             sp_n,
   output logic                      accept,
   output logic [CW-1:0]             cnt,
   output logic                      ovf,
   output logic                      udf
);

   localparam stack_mode_t MODE = (WRAP != 0) ? STACK_WRAP : STACK_GUARD;
   localparam logic signed [CW:0] DEPTH_S = (CW+1)'(DEPTH);

   logic [AW-1:0]      sp_q, sp_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic               ovf_q, ovf_d, udf_q, udf_d;
   logic signed [CW:0] dx, c_n;
   logic               ovf_evt, udf_evt;

   always_comb begin
      dx      = {{(CW+1-DELTA_W){delta[DELTA_W-1]}}, delta};
      sp_n    = sp_q + dx[AW-1:0];
      // One extra bit keeps the signed sum from aliasing at either bound
      c_n     = $signed({1'b0, cnt_q}) + dx;
      ovf_evt = en && (c_n > DEPTH_S);
      udf_evt = en && (c_n < 0);
      accept  = en && ((MODE == STACK_WRAP) || !(ovf_evt || udf_evt));

      sp_d  = sp_q;
      cnt_d = cnt_q;
      if (accept) begin
         sp_d = sp_n;
         if (udf_evt)      cnt_d = '0;
         else if (ovf_evt) cnt_d = CW'(DEPTH);
         else              cnt_d = c_n[CW-1:0];
      end

      ovf_d = ovf_q;
      if (ovf_evt)      ovf_d = 1'b1;
      else if (err_clr) ovf_d = 1'b0;
      udf_d = udf_q;
      if (udf_evt)      udf_d = 1'b1;
      else if (err_clr) udf_d = 1'b0;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sp_q  <= '0;
         cnt_q <= '0;
         ovf_q <= 1'b0;
         udf_q <= 1'b0;
      end else begin
         sp_q  <= sp_d;
         cnt_q <= cnt_d;
         ovf_q <= ovf_d;
         udf_q <= udf_d;
      end
   end

   assign sp  = sp_q;
   assign cnt = cnt_q;
   assign ovf = ovf_q;
   assign udf = udf_q;

endmodule

// File: rtl/j1_stack_v2.sv
// Parametrised J1 LIFO stack: flop storage with combinational top/second reads.
module j1_stack_v2
   import j1_stack_v2_pkg::*;
#(
   parameter int WIDTH   = J1_WIDTH,
   parameter int DEPTH   = J1_DSTACK_DEPTH,
   parameter int DELTA_W = 2,
   parameter int WRAP    = 1,
   localparam int AW     = $clog2(DEPTH),
   localparam int CW     = AW + 1
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      en,
   input  logic signed [DELTA_W-1:0] delta,
   input  logic                      wr,
   input  logic [WIDTH-1:0]          wdata,
   input  logic                      err_clr,
   output logic [WIDTH-1:0]          top,
   output logic [WIDTH-1:0]          second,
   output logic [CW-1:0]             depth,
   output logic                      empty,
   output logic                      full,
   output logic                      overflow,
   output logic                      underflow
);

   if ((DEPTH < 4) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
      $error("j1_stack_v2: DEPTH must be a power of two and at least 4");
   end

   logic [AW-1:0]    sp, sp_n;
   logic             accept;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];

   j1_stack_ptr #(
      .DEPTH   (DEPTH),
      .DELTA_W (DELTA_W),
      .WRAP    (WRAP)
   ) u_ptr (
      .clk     (clk),
      .reset   (reset),
      .en      (en),
      .delta   (delta),
      .err_clr (err_clr),
      .sp      (sp),
      .sp_n    (sp_n),
      .accept  (accept),
      .cnt     (cnt),
      .ovf     (overflow),
      .udf     (underflow)
   );

   // A rejected guarded step also drops its write
   always_comb begin
      mem_d = mem_q;
      if (wr) begin
         if (!en)         mem_d[sp]   = wdata;
         else if (accept) mem_d[sp_n] = wdata;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else begin
         mem_q <= mem_d;
      end
   end

   assign top    = mem_q[sp];
   assign second = mem_q[sp - AW'(1)];
   assign depth  = cnt;
   assign empty  = (cnt == '0);
   assign full   = (cnt == CW'(DEPTH));

endmodule

// File: tb/tb_j1_stack_v2.sv
// Random + directed check of wrap and guard stacks against an integer array model.
module tb_j1_stack_v2;

   localparam int W = 16;
   localparam int D = 4;

   logic             clk = 1'b0;
   logic             reset;
   logic             en, wr, err_clr;
   logic [1:0]       delta;
   logic [W-1:0]     wdata;
   logic [1:0][W-1:0] top_o, sec_o;
   logic [1:0][2:0]  dep_o;
   logic [1:0]       emp_o, ful_o, ovf_o, udf_o;

   int n_chk = 0;
   int n_fail = 0;

   // model state: index 0 = wrap instance, 1 = guard instance
   logic [W-1:0] m_mem [2][D];
   int           m_sp  [2];
   int           m_cnt [2];
   bit           m_ovf [2];
   bit           m_udf [2];

   always #5 clk = ~clk;

   j1_stack_v2 #(.WIDTH(W), .DEPTH(D), .DELTA_W(2), .WRAP(1)) u_wrap (
      .clk(clk), .reset(reset), .en(en), .delta(delta), .wr(wr), .wdata(wdata),
      .err_clr(err_clr), .top(top_o[0]), .second(sec_o[0]), .depth(dep_o[0]),
      .empty(emp_o[0]), .full(ful_o[0]), .overflow(ovf_o[0]), .underflow(udf_o[0])
   );

   j1_stack_v2 #(.WIDTH(W), .DEPTH(D), .DELTA_W(2), .WRAP(0)) u_guard (
      .clk(clk), .reset(reset), .en(en), .delta(delta), .wr(wr), .wdata(wdata),
      .err_clr(err_clr), .top(top_o[1]), .second(sec_o[1]), .depth(dep_o[1]),
      .empty(emp_o[1]), .full(ful_o[1]), .overflow(ovf_o[1]), .underflow(udf_o[1])
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         for (int j = 0; j < D; j++) m_mem[i][j] = '0;
         m_sp[i] = 0; m_cnt[i] = 0; m_ovf[i] = 0; m_udf[i] = 0;
      end
   endtask

   task automatic model_step(input bit e, input int d, input bit w, input logic [W-1:0] wd, input bit clr);
      for (int i = 0; i < 2; i++) begin
         bit eo, eu;
         int c, spn;
         eo = 0; eu = 0;
         if (e) begin
            c   = m_cnt[i] + d;
            spn = ((m_sp[i] + d) % D + D) % D;
            eo  = (c > D);
            eu  = (c < 0);
            if (i == 0 || !(eo || eu)) begin
               if (w) m_mem[i][spn] = wd;
               m_sp[i]  = spn;
               m_cnt[i] = (c < 0) ? 0 : (c > D) ? D : c;
            end
         end else if (w) begin
            m_mem[i][m_sp[i]] = wd;
         end
         if (eo) m_ovf[i] = 1; else if (clr) m_ovf[i] = 0;
         if (eu) m_udf[i] = 1; else if (clr) m_udf[i] = 0;
      end
   endtask

   task automatic check_all(input string tag);
      for (int i = 0; i < 2; i++) begin
         string p;
         p = {tag, (i == 0) ? ".wrap" : ".guard"};
         check({p, ".top"},    32'(top_o[i]), 32'(m_mem[i][m_sp[i]]));
         check({p, ".second"}, 32'(sec_o[i]), 32'(m_mem[i][(m_sp[i] + D - 1) % D]));
         check({p, ".depth"},  32'(dep_o[i]), 32'(m_cnt[i]));
         check({p, ".empty"},  32'(emp_o[i]), 32'(m_cnt[i] == 0));
         check({p, ".full"},   32'(ful_o[i]), 32'(m_cnt[i] == D));
         check({p, ".ovf"},    32'(ovf_o[i]), 32'(m_ovf[i]));
         check({p, ".udf"},    32'(udf_o[i]), 32'(m_udf[i]));
      end
   endtask

   // Apply one cycle of inputs, then compare everything #1 after the edge
   task automatic step(input string tag, input bit e, input int d, input bit w,
                       input logic [W-1:0] wd, input bit clr);
      en = e; delta = 2'(d); wr = w; wdata = wd; err_clr = clr;
      @(posedge clk);
      #1;
      model_step(e, d, w, wd, clr);
      check_all(tag);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      #3;
      model_reset();
      reset = 1'b0;
   endtask

   initial begin
      en = 0; delta = 0; wr = 0; wdata = '0; err_clr = 0;
      reset = 1'b1;
      model_reset();
      #12;
      check_all("reset");
      reset = 1'b0;
      @(posedge clk); #1;

      // basic pushes up to full, then overflow in both modes
      step("push1", 1, 1, 1, 16'h1111, 0);
      step("push2", 1, 1, 1, 16'h2222, 0);
      step("push3", 1, 1, 1, 16'h3333, 0);
      check("push3.top",    32'(top_o[0]), 32'h3333);
      check("push3.second", 32'(sec_o[0]), 32'h2222);
      step("push4", 1, 1, 1, 16'h4444, 0);
      check("push4.full", 32'(ful_o[1]), 32'h1);
      step("push5", 1, 1, 1, 16'h5555, 0);
      check("ovf.wrap.top",     32'(top_o[0]), 32'h5555);
      check("ovf.wrap.second",  32'(sec_o[0]), 32'h4444);
      check("ovf.guard.top",    32'(top_o[1]), 32'h4444);
      check("ovf.guard.second", 32'(sec_o[1]), 32'h3333);
      check("ovf.guard.depth",  32'(dep_o[1]), 32'd4);

      // underflow from depth 1, clear, then clear colliding with a new event
      @(negedge clk); do_reset();
      step("u.push", 1, 1, 1, 16'hAAAA, 0);
      step("u.pop2", 1, -2, 0, 16'h0, 0);
      check("udf.guard.depth", 32'(dep_o[1]), 32'd1);
      check("udf.guard.top",   32'(top_o[1]), 32'hAAAA);
      step("u.clr", 0, 0, 0, 16'h0, 1);
      check("udf.cleared", 32'(udf_o[1]), 32'h0);
      step("u.clr_evt", 1, -2, 0, 16'h0, 1);
      check("udf.set_wins", 32'(udf_o[1]), 32'h1);
      step("u.clr2", 0, 0, 0, 16'h0, 1);

      // replace top at depth 2, and delta 0 with en
      step("r.push", 1, 1, 1, 16'h0B0B, 0);
      step("r.repl", 0, 0, 1, 16'hBEEF, 0);
      check("repl.top",   32'(top_o[1]), 32'hBEEF);
      check("repl.depth", 32'(dep_o[1]), 32'd2);
      step("r.zero", 1, 0, 1, 16'hCAFE, 0);

      // async reset mid-cycle while full, with a push pending
      step("a.push3", 1, 1, 1, 16'h0303, 0);
      step("a.push4", 1, 1, 1, 16'h0404, 0);
      en = 1; delta = 2'd1; wr = 1; wdata = 16'hDEAD; err_clr = 0;
      #3;
      reset = 1'b1;
      #1;
      model_reset();
      check_all("async");
      @(posedge clk); #1;
      check_all("async.hold");
      reset = 1'b0;
      step("a.push", 1, 1, 1, 16'h0001, 0);
      check("async.top",   32'(top_o[0]), 32'h0001);
      check("async.depth", 32'(dep_o[0]), 32'd1);

      // random traffic
      for (int k = 0; k < 400; k++) begin
         step("rand", ($urandom_range(0, 3) != 0), int'($urandom_range(0, 3)) - 2,
              $urandom_range(0, 1), 16'($urandom), ($urandom_range(0, 9) == 0));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
